// File: rtl/extruder_seq_pkg.sv
// Shared types and constants for the extruder move sequencer.
// Holds the FSM encoding, the queued command bundle and null-move detection.
package extruder_seq_pkg;

  localparam int STEP_W  = 32;
  localparam int SPEED_W = 32;
  localparam int CNT_W   = 16;

  localparam logic [STEP_W-1:0] NULL_MASK = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    RELEASE
  } seq_state_t;

  typedef struct packed {
    logic [SPEED_W-1:0] speed;
    logic [STEP_W-1:0]  steps;
  } move_cmd_t;

  function automatic logic is_null(
    input logic [STEP_W-1:0] s
  );
    return (s & NULL_MASK) == '0;
  endfunction

endpackage

// File: rtl/extruder_cmd_fifo.sv
// Synchronous command FIFO with flush; flush beats push and pop.
// Read data is the combinational head entry.
module extruder_cmd_fifo
  import extruder_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  move_cmd_t                din,
  output move_cmd_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  move_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/extruder_move_sequencer.sv
// Queues extrusion moves and hands them to the stepper driver one by one.
// Optional start timeout: define EXTRUDER_SEQ_TIMEOUT_EN.
module extruder_move_sequencer
  import extruder_seq_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [STEP_W-1:0]             cmd_steps,
  input  logic [SPEED_W-1:0]            cmd_speed,
  input  logic                          abort,
  output logic [STEP_W-1:0]             stepper_step_in,
  output logic [SPEED_W-1:0]            stepper_speed,
  output logic                          start_driving,
  input  logic                          stepper_driving,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              moves_done,
  output logic                          error
);

  seq_state_t state;
  seq_state_t state_nx;
  move_cmd_t  in_cmd;
  move_cmd_t  head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       load;
  logic       count;
  logic       start_nx;
  logic       to_hit;

  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign in_cmd    = '{speed: cmd_speed, steps: cmd_steps};
  assign busy      = (state != IDLE) || !empty;

  extruder_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (in_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef EXTRUDER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  logic [TW-1:0] arm_cnt;
  logic          err_q;

  assign to_hit = arm_cnt == TW'(START_TIMEOUT - 1);
  assign error  = err_q;

  // ARM wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ARM && state_nx == ARM)
        arm_cnt <= arm_cnt + 1'b1;
      else
        arm_cnt <= '0;
      if (state == ARM && to_hit &&
          !abort && !stepper_driving)
        err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign error  = 1'b0;
`endif

  // next state, pop/load/count strobes
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    count    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!abort && !empty) begin
          pop = 1'b1;
          if (!is_null(head.steps)) begin
            load     = 1'b1;
            state_nx = ARM;
          end
        end
      end
      ARM: begin
        if (abort)                state_nx = RELEASE;
        else if (stepper_driving) state_nx = RUN;
        else if (to_hit)          state_nx = RELEASE;
      end
      RUN: begin
        if (abort) begin
          state_nx = RELEASE;
        end else if (!stepper_driving) begin
          state_nx = RELEASE;
          count    = 1'b1;
        end
      end
      RELEASE: begin
        if (!stepper_driving) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    start_nx = (state == ARM || state == RUN) &&
               (state_nx == ARM || state_nx == RUN);
  end

  // state register and handshake output
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      start_driving <= 1'b0;
    end else begin
      state         <= state_nx;
      start_driving <= start_nx;
    end
  end

  // move parameters and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stepper_step_in <= '0;
      stepper_speed   <= '0;
      moves_done      <= '0;
    end else begin
      if (count) moves_done <= moves_done + 1'b1;
      if (load) begin
        stepper_step_in <= head.steps;
        stepper_speed   <= (head.speed == '0) ?
                           SPEED_W'(1) : head.speed;
      end
    end
  end

endmodule

// File: tb/tb_extruder_move_sequencer.sv
// Directed bench for extruder_move_sequencer with a simple driver model.
// Timeout scenario follows EXTRUDER_SEQ_TIMEOUT_EN.
module tb_extruder_move_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_steps = '0;
  logic [31:0] cmd_speed = '0;
  logic        abort = 1'b0;
  logic [31:0] stepper_step_in;
  logic [31:0] stepper_speed;
  logic        start_driving;
  logic        stepper_driving;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] moves_done;
  logic        error;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        drv_en = 1'b1;
  int          drv_len = 3;
  int          drv_cnt;
  logic        drv_done;
  logic        sd_q;
  logic [31:0] step_q;
  int          stable_err = 0;
  logic [31:0] issued [$];
  logic [15:0] base;

  extruder_move_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_steps       (cmd_steps),
    .cmd_speed       (cmd_speed),
    .abort           (abort),
    .stepper_step_in (stepper_step_in),
    .stepper_speed   (stepper_speed),
    .start_driving   (start_driving),
    .stepper_driving (stepper_driving),
    .busy            (busy),
    .fifo_level      (fifo_level),
    .moves_done      (moves_done),
    .error           (error)
  );

  always #5 clk = ~clk;

  // driver: answer start with a drv_len-cycle move, wait for re-arm
  always @(posedge clk) begin
    if (rst || !drv_en) begin
      stepper_driving <= 1'b0;
      drv_cnt         <= 0;
      drv_done        <= 1'b0;
    end else if (!start_driving) begin
      stepper_driving <= 1'b0;
      drv_done        <= 1'b0;
    end else if (!drv_done) begin
      if (!stepper_driving) begin
        stepper_driving <= 1'b1;
        drv_cnt         <= drv_len;
      end else if (drv_cnt == 0) begin
        stepper_driving <= 1'b0;
        drv_done        <= 1'b1;
      end else begin
        drv_cnt <= drv_cnt - 1;
      end
    end
  end

  // log issued moves; flag parameter changes while driving
  always @(posedge clk) begin
    sd_q   <= start_driving;
    step_q <= stepper_step_in;
    if (start_driving && !sd_q)
      issued.push_back(stepper_step_in);
    if (start_driving && sd_q &&
        stepper_step_in != step_q)
      stable_err = stable_err + 1;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(
    input logic [31:0] s,
    input logic [31:0] sp
  );
    cmd_valid = 1'b1;
    cmd_steps = s;
    cmd_speed = sp;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] iss(input int k);
    return (issued.size() > k) ? issued[k] : 'x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_start", start_driving, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_moves", moves_done, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_step", stepper_step_in, 0);
    check("rst_speed", stepper_speed, 0);

    // 1: single move, latency
    push(32'd4, 32'd2);
    check("t1_start_t", start_driving, 0);
    check("t1_level_t", fifo_level, 1);
    @(negedge clk);
    check("t1_start_t1", start_driving, 0);
    check("t1_level_t1", fifo_level, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_start_t2", start_driving, 1);
    check("t1_step", stepper_step_in, 4);
    check("t1_speed", stepper_speed, 2);
    for (int i = 0; i < 50 && moves_done != 1; i++)
      @(negedge clk);
    check("t1_moves", moves_done, 1);
    check("t1_start_low", start_driving, 0);
    for (int i = 0; i < 20 && busy; i++)
      @(negedge clk);
    check("t1_idle", busy, 0);

    // 2: fill FIFO, ordering, negative step
    drv_en = 1'b0;
    issued.delete();
    base = moves_done;
    push(32'd5, 32'd1);
    push(32'hFFFF_FFFD, 32'd1);
    push(32'd7, 32'd1);
    push(32'd2, 32'd1);
    push(32'd11, 32'd1);
    check("t2_level_full", fifo_level, 4);
    check("t2_ready_full", cmd_ready, 0);
    push(32'd13, 32'd1);
    check("t2_level_keep", fifo_level, 4);
    drv_en = 1'b1;
    for (int i = 0; i < 300 && moves_done != base + 5; i++)
      @(negedge clk);
    check("t2_moves", moves_done, base + 5);
    check("t2_n_issued", issued.size(), 5);
    check("t2_iss0", iss(0), 32'd5);
    check("t2_iss1", iss(1), 32'hFFFF_FFFD);
    check("t2_iss2", iss(2), 32'd7);
    check("t2_iss3", iss(3), 32'd2);
    check("t2_iss4", iss(4), 32'd11);
    for (int i = 0; i < 20 && busy; i++)
      @(negedge clk);

    // 3: null moves skipped, speed clamp
    issued.delete();
    base = moves_done;
    push(32'd0, 32'd5);
    push(32'h8000_0000, 32'd5);
    push(32'd3, 32'd0);
    for (int i = 0; i < 100 && busy; i++)
      @(negedge clk);
    check("t3_moves", moves_done, base + 1);
    check("t3_n_issued", issued.size(), 1);
    check("t3_iss0", iss(0), 32'd3);
    check("t3_speed", stepper_speed, 1);

    // 4: abort during RUN with two queued
    drv_len = 20;
    drv_en  = 1'b0;
    base    = moves_done;
    push(32'd8, 32'd1);
    push(32'd21, 32'd1);
    push(32'd22, 32'd1);
    check("t4_level", fifo_level, 2);
    drv_en = 1'b1;
    for (int i = 0; i < 20 && !stepper_driving; i++)
      @(negedge clk);
    @(negedge clk);
    check("t4_running", start_driving, 1);
    abort = 1'b1;
    #1;
    check("t4_ready_abort", cmd_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    check("t4_start", start_driving, 0);
    check("t4_level", fifo_level, 0);
    check("t4_moves", moves_done, base);
    for (int i = 0; i < 20 && busy; i++)
      @(negedge clk);
    check("t4_idle", busy, 0);
    check("t4_moves_end", moves_done, base);
    drv_len = 3;

    // 5: driver never answers
    drv_en = 1'b0;
    base   = moves_done;
`ifdef EXTRUDER_SEQ_TIMEOUT_EN
    issued.delete();
    push(32'd6, 32'd1);
    push(32'd7, 32'd1);
    for (int i = 0; i < 40 && !error; i++)
      @(negedge clk);
    check("t5_error", error, 1);
    for (int i = 0; i < 10 && !start_driving; i++)
      @(negedge clk);
    check("t5_next_start", start_driving, 1);
    check("t5_next_step", stepper_step_in, 7);
    drv_en = 1'b1;
    for (int i = 0; i < 50 && busy; i++)
      @(negedge clk);
    check("t5_moves", moves_done, base + 1);
    check("t5_error_sticky", error, 1);
`else
    push(32'd6, 32'd1);
    repeat (30) @(negedge clk);
    check("t5_hold_start", start_driving, 1);
    check("t5_no_error", error, 0);
    check("t5_busy", busy, 1);
    check("t5_step", stepper_step_in, 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 10 && busy; i++)
      @(negedge clk);
    check("t5_idle", busy, 0);
    check("t5_moves", moves_done, base);
    drv_en = 1'b1;
`endif

    // 6: reset during RUN
    drv_len = 20;
    drv_en  = 1'b0;
    push(32'd9, 32'd1);
    push(32'd10, 32'd1);
    drv_en = 1'b1;
    for (int i = 0; i < 20 && !stepper_driving; i++)
      @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_start", start_driving, 0);
    check("t6_level", fifo_level, 0);
    check("t6_moves", moves_done, 0);
    check("t6_ready", cmd_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_error", error, 0);

    check("stable_params", stable_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
